// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern matcher and its run-control wrapper.
//   state_t         : control FSM encoding (IDLE=0, ARMED=1, DONE=2; 3 is illegal)
//   DEF_PATTERN_RAW : reset pattern 1011001, LSB-aligned in a wide vector
//                     so any PAT_W up to 64 can take its low bits
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [63:0] DEF_PATTERN_RAW = 64'b1011001;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: history shift register, fill counter and masked
// comparator. hit is combinational and valid in the cycle the bit is shifted.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear history and fill
//   shift     : shift data_bit into the history this cycle
//   data_bit  : serial data bit
//   pattern   : pattern, MSB = oldest bit
//   mask      : 1 = compare bit, 0 = don't-care
//   hit       : the history including data_bit matches the pattern
module seq_match_core #(
    parameter int PAT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             data_bit,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Only the newest PAT_W-1 bits are ever needed for the next history,
    // so the oldest bit is not stored.
    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] hist_n;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_n;

    always_comb begin
        hist_n = {hist, data_bit};
        fill_n = (fill == FILL_FULL) ? fill : fill + 1'b1;
        hit    = shift && (fill_n == FILL_FULL)
                 && (((hist_n ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_n[PAT_W-2:0];
            fill <= fill_n;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-control wrapper around a programmable serial pattern matcher.
// Host loads pattern/mask/target/timeout in IDLE, starts the block, and it
// counts overlapping matches until the target or the idle timeout is reached,
// then holds a level irq until acknowledged.
//   clk, rst      : clock, synchronous active-high reset
//   cfg_we        : load cfg_* registers (IDLE only)
//   cfg_pattern   : pattern, MSB = oldest bit
//   cfg_mask      : 1 = compare bit, 0 = don't-care
//   cfg_target    : matches required (0 behaves as 1)
//   cfg_timeout   : idle-cycle limit while ARMED (0 = disabled)
//   start         : IDLE -> ARMED
//   abort         : any state -> IDLE, no irq
//   datain        : serial data bit, qualified by din_valid
//   irq_ack       : clears irq in DONE
//   match_pulse   : one-cycle pulse per match
//   match_cnt     : matches since last start (saturating)
//   irq           : level, set on entering DONE
//   timeout_flag  : DONE reached via timeout
//   busy          : state != IDLE
//   state         : IDLE=0, ARMED=1, DONE=2
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 7,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             start,
    input  logic             abort,
    input  logic             datain,
    input  logic             din_valid,
    input  logic             irq_ack,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    output logic             timeout_flag,
    output logic             busy,
    output logic [1:0]       state
);

    localparam logic [PAT_W-1:0] RST_PATTERN = DEF_PATTERN_RAW[PAT_W-1:0];

    state_t           state_q;
    logic [PAT_W-1:0] pattern_q;
    logic [PAT_W-1:0] mask_q;
    logic [CNT_W-1:0] target_q;
    logic [TMO_W-1:0] timeout_q;
    logic [TMO_W-1:0] timer;

    logic             shift;
    logic             clr;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] target_eff;
    logic             tmo_expire;

    always_comb begin
        shift      = (state_q == ST_ARMED) && din_valid && !abort;
        clr        = abort || ((state_q == ST_IDLE) && start);
        cnt_inc    = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;
        target_eff = (target_q == '0) ? CNT_W'(1) : target_q;
        tmo_expire = (timeout_q != '0) && (timer == timeout_q - TMO_W'(1));
    end

    seq_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift    (shift),
        .data_bit (datain),
        .pattern  (pattern_q),
        .mask     (mask_q),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pattern_q    <= RST_PATTERN;
            mask_q       <= '1;
            target_q     <= CNT_W'(1);
            timeout_q    <= '0;
            timer        <= '0;
            match_pulse  <= 1'b0;
            match_cnt    <= '0;
            irq          <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                irq     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cfg_we) begin
                            pattern_q <= cfg_pattern;
                            mask_q    <= cfg_mask;
                            target_q  <= cfg_target;
                            timeout_q <= cfg_timeout;
                        end
                        if (start) begin
                            match_cnt    <= '0;
                            timeout_flag <= 1'b0;
                            timer        <= '0;
                            state_q      <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        // A hit on the same edge as expiry wins and restarts the timer.
                        if (hit) begin
                            match_pulse <= 1'b1;
                            match_cnt   <= cnt_inc;
                            timer       <= '0;
                            if (cnt_inc >= target_eff) begin
                                state_q <= ST_DONE;
                                irq     <= 1'b1;
                            end
                        end else if (tmo_expire) begin
                            state_q      <= ST_DONE;
                            irq          <= 1'b1;
                            timeout_flag <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (irq_ack) begin
                            state_q <= ST_IDLE;
                            irq     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        irq     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = state_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
